// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types plus fetch-stage state and PC step.
package lc3b_types;

  typedef logic [15:0] lc3b_word;

  typedef enum logic [3:0] {
    op_br   = 4'b0000,
    op_add  = 4'b0001,
    op_ldb  = 4'b0010,
    op_stb  = 4'b0011,
    op_jsr  = 4'b0100,
    op_and  = 4'b0101,
    op_ldr  = 4'b0110,
    op_str  = 4'b0111,
    op_rti  = 4'b1000,
    op_not  = 4'b1001,
    op_ldi  = 4'b1010,
    op_sti  = 4'b1011,
    op_jmp  = 4'b1100,
    op_shf  = 4'b1101,
    op_lea  = 4'b1110,
    op_trap = 4'b1111
  } lc3b_opcode;

  typedef enum logic [1:0] {
    s_start,
    s_fetch,
    s_hold
  } lc3b_fetch_state;

  localparam lc3b_word lc3b_pc_step = 16'd2;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: memory read/resp channel, redirect input, decode valid/ready channel.
interface fetch_unit_if;
  import lc3b_types::*;

  lc3b_word   mem_address;
  logic       mem_read;
  lc3b_word   mem_rdata;
  logic       mem_resp;
  logic       redirect;
  lc3b_word   redirect_pc;
  logic       instr_valid;
  logic       instr_ready;
  lc3b_word   instr;
  lc3b_opcode opcode;
  lc3b_word   instr_pc;

  modport master (
    output mem_address, mem_read, instr_valid, instr, opcode, instr_pc,
    input  mem_rdata, mem_resp, redirect, redirect_pc, instr_ready
  );

  modport slave (
    input  mem_address, mem_read, instr_valid, instr, opcode, instr_pc,
    output mem_rdata, mem_resp, redirect, redirect_pc, instr_ready
  );

endinterface

// File: rtl/fetch_unit_pc_reg.sv
// Fetch PC with load/increment mux, plus squash flag and its deferred redirect target.
// Latency: all updates visible the cycle after the control strobe. No backpressure.
module fetch_unit_pc_reg
  import lc3b_types::*;
#(
  parameter lc3b_word RESET_PC = 16'h0000
) (
  input  logic     clk,
  input  logic     reset_n,
  input  logic     pc_load,
  input  logic     pc_inc,
  input  logic     squash_set,
  input  logic     squash_clr,
  input  lc3b_word redirect_pc,
  output lc3b_word pc,
  output logic     squash
);

  lc3b_word target;
  lc3b_word redirect_aligned;

  assign redirect_aligned = redirect_pc & 16'hFFFE;

  // A live redirect beats a pending squash target; both beat sequential increment.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc     <= RESET_PC;
      squash <= 1'b0;
      target <= '0;
    end else begin
      if (pc_load) begin
        pc <= redirect_aligned;
      end else if (squash_clr) begin
        pc <= target;
      end else if (pc_inc) begin
        pc <= pc + lc3b_pc_step;
      end

      if (squash_set) begin
        squash <= 1'b1;
        target <= redirect_aligned;
      end else if (squash_clr) begin
        squash <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// LC-3b fetch front end: owns PC, reads one instruction word at a time, holds it for decode.
// Latency: instr_valid the cycle after mem_resp; no prefetch, so issue interval is read latency + 2.
// Backpressure: instruction held stable while instr_ready is low; redirect drops it regardless.
module fetch_unit
  import lc3b_types::*;
#(
  parameter lc3b_word RESET_PC = 16'h0000
) (
  input  logic          clk,
  input  logic          reset_n,
  fetch_unit_if.master  bus
);

  lc3b_fetch_state state, state_n;
  lc3b_word        pc;
  lc3b_word        instr;
  lc3b_word        instr_pc;
  logic            squash;
  logic            pc_load;
  logic            pc_inc;
  logic            squash_set;
  logic            squash_clr;
  logic            ir_load;

  fetch_unit_pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
    .clk         (clk),
    .reset_n     (reset_n),
    .pc_load     (pc_load),
    .pc_inc      (pc_inc),
    .squash_set  (squash_set),
    .squash_clr  (squash_clr),
    .redirect_pc (bus.redirect_pc),
    .pc          (pc),
    .squash      (squash)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= s_start;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      instr    <= '0;
      instr_pc <= '0;
    end else if (ir_load) begin
      instr    <= bus.mem_rdata;
      instr_pc <= pc;
    end
  end

  // A redirect during an outstanding read cannot cancel it; it arms squash and the
  // response is thrown away before refetching from the target.
  always_comb begin
    state_n    = state;
    pc_load    = 1'b0;
    pc_inc     = 1'b0;
    squash_set = 1'b0;
    squash_clr = 1'b0;
    ir_load    = 1'b0;
    case (state)
      s_start: begin
        state_n = s_fetch;
        pc_load = bus.redirect;
      end
      s_fetch: begin
        if (bus.mem_resp) begin
          if (!squash && !bus.redirect) begin
            ir_load = 1'b1;
            pc_inc  = 1'b1;
            state_n = s_hold;
          end else begin
            pc_load    = bus.redirect;
            squash_clr = 1'b1;
          end
        end else if (bus.redirect) begin
          squash_set = 1'b1;
        end
      end
      s_hold: begin
        if (bus.redirect) begin
          pc_load = 1'b1;
          state_n = s_fetch;
        end else if (bus.instr_ready) begin
          state_n = s_fetch;
        end
      end
      default: state_n = s_start;
    endcase
  end

  assign bus.mem_address = pc;
  assign bus.mem_read    = (state == s_fetch);
  assign bus.instr_valid = (state == s_hold);
  assign bus.instr       = instr;
  assign bus.instr_pc    = instr_pc;
  assign bus.opcode      = lc3b_opcode'(instr[15:12]);

  a_resp_only_in_fetch: assert property (
    @(posedge clk) disable iff (!reset_n) bus.mem_resp |-> (state == s_fetch)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios then random ready/redirect/latency,
// scoreboard of expected (pc, word) pairs checked on every decode transfer.
module tb_fetch_unit;
  import lc3b_types::*;

  localparam logic [15:0] RST_PC = 16'hFFFE;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] word;
  } exp_t;

  logic clk;
  logic reset_n;
  int   total = 0;
  int   bad = 0;
  int   xfer_cnt = 0;
  int   fixed_lat = 0;
  bit   stray_req = 0;
  exp_t exp_q[$];

  fetch_unit_if bus();

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    logic [15:0] h;
    if (a == 16'h0000) return 16'h1283;
    h = a * 16'h9E37;
    return h ^ 16'h5A5A ^ {a[7:0], a[15:8]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!bus.instr_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("wait_valid", 32'(bus.instr_valid), 32'd1);
  endtask

  // Memory: answers each read after 'fixed_lat' cycles (random 0..3 when negative).
  initial begin
    int wait_cnt = 0;
    bus.mem_resp  = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      tick();
      if (bus.mem_resp) begin
        bus.mem_resp = 1'b0;
        wait_cnt = (fixed_lat < 0) ? int'($urandom_range(0, 3)) : fixed_lat;
      end else if (stray_req) begin
        stray_req     = 1'b0;
        bus.mem_resp  = 1'b1;
        bus.mem_rdata = 16'hDEAD;
      end else if (bus.mem_read) begin
        if (wait_cnt == 0) begin
          bus.mem_resp  = 1'b1;
          bus.mem_rdata = mem_word(bus.mem_address);
        end else begin
          wait_cnt--;
        end
      end else begin
        wait_cnt = (fixed_lat < 0) ? int'($urandom_range(0, 3)) : fixed_lat;
      end
    end
  end

  // Reference model + monitor: after any redirect the next delivered instruction
  // comes from the last target; otherwise deliveries are sequential by 2.
  logic        p_rst = 1'b0, p_valid = 1'b0, p_xfer = 1'b0, p_redir = 1'b0;
  logic        p_mread = 1'b0, p_resp = 1'b0;
  logic [15:0] p_instr = '0, p_ipc = '0, p_addr = '0;

  always @(negedge clk) begin
    exp_t        e;
    logic        xfer;
    logic [15:0] npc;
    xfer = 1'b0;
    if (!reset_n) begin
      exp_q.delete();
      exp_q.push_back('{RST_PC, mem_word(RST_PC)});
    end else if (bus.redirect) begin
      npc = bus.redirect_pc & 16'hFFFE;
      exp_q.delete();
      exp_q.push_back('{npc, mem_word(npc)});
    end else if (bus.instr_valid && bus.instr_ready) begin
      xfer = 1'b1;
      xfer_cnt++;
      if (exp_q.size() == 0) begin
        check("sb_nonempty", 32'd0, 32'd1);
      end else begin
        e = exp_q.pop_front();
        check("xfer_pc", 32'(bus.instr_pc), 32'(e.pc));
        check("xfer_instr", 32'(bus.instr), 32'(e.word));
        check("xfer_opcode", 32'(bus.opcode), 32'(e.word[15:12]));
        npc = e.pc + 16'd2;
        exp_q.push_back('{npc, mem_word(npc)});
      end
    end
    if (reset_n) begin
      check("read_xor_valid", 32'(bus.mem_read & bus.instr_valid), 32'd0);
      if (p_rst && p_valid && !p_xfer && !p_redir) begin
        check("hold_valid", 32'(bus.instr_valid), 32'd1);
        check("hold_instr", 32'(bus.instr), 32'(p_instr));
        check("hold_pc", 32'(bus.instr_pc), 32'(p_ipc));
      end
      if (p_rst && p_mread && !p_resp) begin
        check("read_held", 32'(bus.mem_read), 32'd1);
        check("addr_stable", 32'(bus.mem_address), 32'(p_addr));
      end
    end
    p_rst   = reset_n;
    p_valid = bus.instr_valid;
    p_xfer  = xfer;
    p_redir = bus.redirect;
    p_instr = bus.instr;
    p_ipc   = bus.instr_pc;
    p_mread = bus.mem_read;
    p_resp  = bus.mem_resp;
    p_addr  = bus.mem_address;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int cnt0;
    reset_n         = 1'b0;
    bus.instr_ready = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    fixed_lat       = 0;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_mem_read", 32'(bus.mem_read), 32'd0);
    check("rst_valid", 32'(bus.instr_valid), 32'd0);
    check("rst_instr", 32'(bus.instr), 32'd0);
    check("rst_instr_pc", 32'(bus.instr_pc), 32'd0);
    check("rst_opcode", 32'(bus.opcode), 32'd0);
    check("rst_addr", 32'(bus.mem_address), 32'(RST_PC));
    tick();
    reset_n = 1'b1;

    // First fetch at RESET_PC (wraps to 0), then the ADD at 0
    @(negedge clk);
    check("start_no_read", 32'(bus.mem_read), 32'd0);
    @(negedge clk);
    check("fetch1_read", 32'(bus.mem_read), 32'd1);
    check("fetch1_addr", 32'(bus.mem_address), 32'(RST_PC));
    @(negedge clk);
    check("wrap_valid", 32'(bus.instr_valid), 32'd1);
    check("wrap_instr_pc", 32'(bus.instr_pc), 32'(RST_PC));
    check("wrap_next_addr", 32'(bus.mem_address), 32'h0000);
    tick();
    bus.instr_ready = 1'b1;
    tick();
    bus.instr_ready = 1'b0;
    @(negedge clk);
    check("add_read", 32'(bus.mem_read), 32'd1);
    check("add_addr", 32'(bus.mem_address), 32'h0000);
    @(negedge clk);
    check("add_valid", 32'(bus.instr_valid), 32'd1);
    check("add_instr", 32'(bus.instr), 32'h1283);
    check("add_opcode", 32'(bus.opcode), 32'(op_add));

    // Back-pressure for 5 cycles
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", 32'(bus.instr_valid), 32'd1);
      check("bp_instr", 32'(bus.instr), 32'h1283);
      check("bp_instr_pc", 32'(bus.instr_pc), 32'h0000);
      check("bp_no_read", 32'(bus.mem_read), 32'd0);
    end
    tick();
    bus.instr_ready = 1'b1;
    tick();
    bus.instr_ready = 1'b0;
    @(negedge clk);
    check("next_addr", 32'(bus.mem_address), 32'h0002);
    @(negedge clk);
    check("next_instr_pc", 32'(bus.instr_pc), 32'h0002);
    @(negedge clk);
    check("no_prefetch", 32'(bus.mem_read), 32'd0);

    // Redirect during a 3-cycle read pending at pc 4
    fixed_lat = 3;
    tick();
    bus.instr_ready = 1'b1;
    tick();
    bus.instr_ready = 1'b0;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'h3001;
    tick();
    bus.redirect = 1'b0;
    n = 0;
    while (n < 10) begin
      @(negedge clk);
      if (bus.mem_resp) break;
      check("sq_addr_held", 32'(bus.mem_address), 32'h0004);
      check("sq_no_valid", 32'(bus.instr_valid), 32'd0);
      n++;
    end
    check("sq_resp_seen", 32'(bus.mem_resp), 32'd1);
    @(negedge clk);
    check("sq_discard", 32'(bus.instr_valid), 32'd0);
    check("sq_new_addr", 32'(bus.mem_address), 32'h3000);
    check("sq_new_read", 32'(bus.mem_read), 32'd1);

    // Redirect concurrent with ready in s_hold
    fixed_lat = 0;
    wait_valid();
    tick();
    bus.instr_ready = 1'b1;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'h0041;
    cnt0 = xfer_cnt;
    tick();
    bus.instr_ready = 1'b0;
    bus.redirect    = 1'b0;
    @(negedge clk);
    check("rd_hold_drop", 32'(bus.instr_valid), 32'd0);
    check("rd_hold_no_xfer", 32'(xfer_cnt), 32'(cnt0));
    check("rd_hold_addr", 32'(bus.mem_address), 32'h0040);
    check("rd_hold_read", 32'(bus.mem_read), 32'd1);

    // Reset asserted mid-read at pc 8, stray response while in reset
    wait_valid();
    fixed_lat = 6;
    tick();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'h0008;
    tick();
    bus.redirect = 1'b0;
    @(negedge clk);
    check("mid_read", 32'(bus.mem_read), 32'd1);
    check("mid_addr", 32'(bus.mem_address), 32'h0008);
    #2;
    reset_n   = 1'b0;
    stray_req = 1'b1;
    #1;
    check("arst_read", 32'(bus.mem_read), 32'd0);
    check("arst_valid", 32'(bus.instr_valid), 32'd0);
    repeat (3) tick();
    check("stray_instr", 32'(bus.instr), 32'd0);
    check("stray_addr", 32'(bus.mem_address), 32'(RST_PC));
    reset_n = 1'b1;
    @(negedge clk);
    check("restart_start", 32'(bus.mem_read), 32'd0);
    @(negedge clk);
    check("restart_read", 32'(bus.mem_read), 32'd1);
    check("restart_addr", 32'(bus.mem_address), 32'(RST_PC));

    // Random traffic
    fixed_lat = -1;
    cnt0 = xfer_cnt;
    for (int i = 0; i < 3000; i++) begin
      tick();
      bus.instr_ready = ($urandom_range(0, 9) < 7);
      bus.redirect    = ($urandom_range(0, 29) == 0);
      bus.redirect_pc = 16'($urandom);
    end
    tick();
    bus.redirect    = 1'b0;
    bus.instr_ready = 1'b1;
    repeat (20) tick();
    check("rand_progress", 32'(xfer_cnt - cnt0 > 200), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
